ubx_rx_parser: RTL and testbench

//  Receive-side UBX frame parser for the GPS link: consumes bytes from the UART receiver, finds
//  B5 62 sync, checks the Fletcher-8 checksum and decodes NAV-POSLLH, NAV-VELNED and ACK-ACK/NAK.
//  It is the counterpart of the config transmitter (CFG-NAV5, CFG-MSG): it confirms configs were

---
 rtl/ubx_rx_parser_pkg.sv | 77 +++++++
 rtl/ubx_rx_parser_fletcher.sv | 32 +++
 rtl/ubx_rx_parser.sv | 197 +++++++++++++++++++
 tb/tb_ubx_rx_parser.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ubx_rx_parser_pkg.sv
// Shared UBX protocol constants and helpers for the receive parser and the config transmitter.
// Holds sync bytes, class/id codes, payload lengths, FSM encoding and message classification.
package ubx_rx_parser_pkg;

    localparam logic [7:0] UBX_SYNC1      = 8'hB5;
    localparam logic [7:0] UBX_SYNC2      = 8'h62;
    localparam logic [7:0] UBX_CLS_NAV    = 8'h01;
    localparam logic [7:0] UBX_CLS_ACK    = 8'h05;
    localparam logic [7:0] UBX_CLS_CFG    = 8'h06;
    localparam logic [7:0] UBX_ID_POSLLH  = 8'h02;
    localparam logic [7:0] UBX_ID_VELNED  = 8'h12;
    localparam logic [7:0] UBX_ID_ACK_ACK = 8'h01;
    localparam logic [7:0] UBX_ID_ACK_NAK = 8'h00;
    localparam logic [7:0] UBX_ID_NAV5    = 8'h24;
    localparam logic [7:0] UBX_ID_MSG     = 8'h01;

    localparam logic [15:0] UBX_LEN_POSLLH = 16'd28;
    localparam logic [15:0] UBX_LEN_VELNED = 16'd36;
    localparam logic [15:0] UBX_LEN_ACK    = 16'd2;

    localparam int NUM_SLOTS = 5;

    typedef enum logic [3:0] {
        ST_SYNC1   = 4'd0,
        ST_SYNC2   = 4'd1,
        ST_CLASS   = 4'd2,
        ST_ID      = 4'd3,
        ST_LEN_LO  = 4'd4,
        ST_LEN_HI  = 4'd5,
        ST_PAYLOAD = 4'd6,
        ST_CK_A    = 4'd7,
        ST_CK_B    = 4'd8
    } ubx_state_t;

    typedef enum logic [1:0] {
        MSG_NONE   = 2'd0,
        MSG_POSLLH = 2'd1,
        MSG_VELNED = 2'd2,
        MSG_ACK    = 2'd3
    } ubx_msg_t;

    // Only exact class/id/length matches are decoded; anything else is consumed silently.
    function automatic ubx_msg_t classify(input logic [7:0] cls, input logic [7:0] id,
                                          input logic [15:0] len);
        classify = MSG_NONE;
        if (cls == UBX_CLS_NAV && id == UBX_ID_POSLLH && len == UBX_LEN_POSLLH)
            classify = MSG_POSLLH;
        else if (cls == UBX_CLS_NAV && id == UBX_ID_VELNED && len == UBX_LEN_VELNED)
            classify = MSG_VELNED;
        else if (cls == UBX_CLS_ACK && (id == UBX_ID_ACK_ACK || id == UBX_ID_ACK_NAK)
                 && len == UBX_LEN_ACK)
            classify = MSG_ACK;
    endfunction

    // Returns {hit, slot[2:0]} for a payload word index of the given message.
    function automatic logic [3:0] word_slot(input ubx_msg_t msg, input logic [7:0] word);
        word_slot = 4'b0000;
        case (msg)
            MSG_POSLLH: case (word)
                8'd1:    word_slot = 4'b1000;
                8'd2:    word_slot = 4'b1001;
                8'd4:    word_slot = 4'b1010;
                default: word_slot = 4'b0000;
            endcase
            MSG_VELNED: case (word)
                8'd1:    word_slot = 4'b1000;
                8'd2:    word_slot = 4'b1001;
                8'd3:    word_slot = 4'b1010;
                8'd5:    word_slot = 4'b1011;
                8'd6:    word_slot = 4'b1100;
                default: word_slot = 4'b0000;
            endcase
            default: word_slot = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ubx_rx_parser_fletcher.sv
// UBX Fletcher-8 running checksum; clear restarts the sum, en folds in one byte.
// Clear together with en starts a fresh sum that already includes the byte.
module ubx_fletcher (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] ck_a,
    output logic [7:0] ck_b
);

    logic [7:0] a_next;
    logic [7:0] b_next;

    assign a_next = (clear ? 8'h00 : ck_a) + data;
    assign b_next = (clear ? 8'h00 : ck_b) + a_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_a <= 8'h00;
            ck_b <= 8'h00;
        end else if (en) begin
            ck_a <= a_next;
            ck_b <= b_next;
        end else if (clear) begin
            ck_a <= 8'h00;
            ck_b <= 8'h00;
        end
    end

endmodule

// File: rtl/ubx_rx_parser.sv
// UBX receive parser: sync hunt, Fletcher check, and NAV-POSLLH / NAV-VELNED / ACK decode.
// Payload fields are staged while the frame streams in and committed only on a good checksum.
module ubx_rx_parser
    import ubx_rx_parser_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic signed [31:0] lon,
    output logic signed [31:0] lat,
    output logic signed [31:0] hmsl,
    output logic signed [31:0] vel_n,
    output logic signed [31:0] vel_e,
    output logic signed [31:0] vel_d,
    output logic [31:0]        gspeed,
    output logic [31:0]        heading,
    output logic               posllh_valid,
    output logic               velned_valid,
    output logic               ack_valid,
    output logic               ack_ok,
    output logic [7:0]         ack_class,
    output logic [7:0]         ack_id,
    output logic               frame_err
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    ubx_state_t state_reg, state_next;

    logic [7:0]       cls_reg;
    logic [7:0]       id_reg;
    logic [7:0]       len_lo_reg;
    logic [15:0]      len_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [23:0]      asm_reg;
    logic             ck_a_ok_reg;
    logic [31:0]      stage_reg [NUM_SLOTS];
    logic [7:0]       ack_cls_stage_reg;
    logic [7:0]       ack_id_stage_reg;

    logic [15:0] len_full;
    logic [31:0] word_next;
    logic        last_byte;
    logic        ck_clear;
    logic        ck_en;
    logic        ck_match;
    logic [3:0]  slot_sel;
    logic [7:0]  ck_a;
    logic [7:0]  ck_b;
    ubx_msg_t    msg;

    assign len_full  = {rx_data, len_lo_reg};
    assign word_next = {rx_data, asm_reg};
    assign last_byte = (16'(idx_reg) == len_reg - 16'd1);
    assign msg       = classify(cls_reg, id_reg, len_reg);
    assign slot_sel  = word_slot(msg, 8'(idx_reg[IDX_W-1:2]));
    assign ck_match  = ck_a_ok_reg && (rx_data == ck_b);

    // The sum restarts as the final sync byte arrives so the CLASS byte is the first term.
    assign ck_clear = rx_valid && (state_reg == ST_SYNC2) && (rx_data == UBX_SYNC2);
    assign ck_en    = rx_valid && (state_reg == ST_CLASS  || state_reg == ST_ID ||
                                   state_reg == ST_LEN_LO || state_reg == ST_LEN_HI ||
                                   state_reg == ST_PAYLOAD);

    ubx_fletcher u_fletcher (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ck_clear),
        .en    (ck_en),
        .data  (rx_data),
        .ck_a  (ck_a),
        .ck_b  (ck_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_SYNC1;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (rx_valid) begin
            case (state_reg)
                ST_SYNC1:   if (rx_data == UBX_SYNC1) state_next = ST_SYNC2;
                ST_SYNC2: begin
                    if (rx_data == UBX_SYNC2)      state_next = ST_CLASS;
                    else if (rx_data != UBX_SYNC1) state_next = ST_SYNC1;
                end
                ST_CLASS:   state_next = ST_ID;
                ST_ID:      state_next = ST_LEN_LO;
                ST_LEN_LO:  state_next = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (len_full > 16'(MAX_LEN)) state_next = ST_SYNC1;
                    else if (len_full == 16'd0)  state_next = ST_CK_A;
                    else                         state_next = ST_PAYLOAD;
                end
                ST_PAYLOAD: if (last_byte) state_next = ST_CK_A;
                ST_CK_A:    state_next = ST_CK_B;
                ST_CK_B:    state_next = ST_SYNC1;
                default:    state_next = ST_SYNC1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_reg           <= '0;
            id_reg            <= '0;
            len_lo_reg        <= '0;
            len_reg           <= '0;
            idx_reg           <= '0;
            asm_reg           <= '0;
            ck_a_ok_reg       <= 1'b0;
            ack_cls_stage_reg <= '0;
            ack_id_stage_reg  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) stage_reg[i] <= '0;
            lon          <= '0;
            lat          <= '0;
            hmsl         <= '0;
            vel_n        <= '0;
            vel_e        <= '0;
            vel_d        <= '0;
            gspeed       <= '0;
            heading      <= '0;
            posllh_valid <= 1'b0;
            velned_valid <= 1'b0;
            ack_valid    <= 1'b0;
            ack_ok       <= 1'b0;
            ack_class    <= '0;
            ack_id       <= '0;
            frame_err    <= 1'b0;
        end else begin
            posllh_valid <= 1'b0;
            velned_valid <= 1'b0;
            ack_valid    <= 1'b0;
            frame_err    <= 1'b0;
            if (rx_valid) begin
                case (state_reg)
                    ST_CLASS:  cls_reg    <= rx_data;
                    ST_ID:     id_reg     <= rx_data;
                    ST_LEN_LO: len_lo_reg <= rx_data;
                    ST_LEN_HI: begin
                        len_reg <= len_full;
                        idx_reg <= '0;
                        if (len_full > 16'(MAX_LEN)) frame_err <= 1'b1;
                    end
                    ST_PAYLOAD: begin
                        asm_reg <= word_next[31:8];
                        idx_reg <= idx_reg + IDX_ONE;
                        if (idx_reg[1:0] == 2'd3 && slot_sel[3])
                            stage_reg[slot_sel[2:0]] <= word_next;
                        if (msg == MSG_ACK && idx_reg == '0)    ack_cls_stage_reg <= rx_data;
                        if (msg == MSG_ACK && idx_reg == IDX_ONE) ack_id_stage_reg <= rx_data;
                    end
                    ST_CK_A: ck_a_ok_reg <= (rx_data == ck_a);
                    ST_CK_B: begin
                        if (!ck_match) begin
                            frame_err <= 1'b1;
                        end else begin
                            case (msg)
                                MSG_POSLLH: begin
                                    lon          <= stage_reg[0];
                                    lat          <= stage_reg[1];
                                    hmsl         <= stage_reg[2];
                                    posllh_valid <= 1'b1;
                                end
                                MSG_VELNED: begin
                                    vel_n        <= stage_reg[0];
                                    vel_e        <= stage_reg[1];
                                    vel_d        <= stage_reg[2];
                                    gspeed       <= stage_reg[3];
                                    heading      <= stage_reg[4];
                                    velned_valid <= 1'b1;
                                end
                                MSG_ACK: begin
                                    ack_class <= ack_cls_stage_reg;
                                    ack_id    <= ack_id_stage_reg;
                                    ack_ok    <= (id_reg == UBX_ID_ACK_ACK);
                                    ack_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ubx_rx_parser.sv
// Scoreboard bench for ubx_rx_parser: directed spec frames plus randomized frame mix.
// A frame-level model predicts each output event; a monitor checks every pulse against it.
module tb_ubx_rx_parser;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic signed [31:0] lon, lat, hmsl, vel_n, vel_e, vel_d;
    logic [31:0]        gspeed, heading;
    logic               posllh_valid, velned_valid, ack_valid, ack_ok, frame_err;
    logic [7:0]         ack_class, ack_id;

    always #5 clk = ~clk;

    ubx_rx_parser #(.MAX_LEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .lon(lon), .lat(lat), .hmsl(hmsl), .vel_n(vel_n), .vel_e(vel_e), .vel_d(vel_d),
        .gspeed(gspeed), .heading(heading), .posllh_valid(posllh_valid),
        .velned_valid(velned_valid), .ack_valid(ack_valid), .ack_ok(ack_ok),
        .ack_class(ack_class), .ack_id(ack_id), .frame_err(frame_err)
    );

    typedef struct {
        int          kind;   // 0 posllh, 1 velned, 2 ack, 3 frame error
        logic [31:0] lon, lat, hmsl, vn, ve, vd, gs, hd;
        logic        ok;
        logic [7:0]  ac, ai;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       model;
    logic [7:0] pl[$];
    int         checks = 0;
    int         errors = 0;
    int         gap_max = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        model = '{kind: 0, lon: 0, lat: 0, hmsl: 0, vn: 0, ve: 0, vd: 0, gs: 0, hd: 0,
                  ok: 0, ac: 0, ai: 0};
    endtask

    task automatic push_kind(input int kind);
        exp_t e;
        e      = model;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] pl_get(input int w);
        return {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
    endfunction

    task automatic pl_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) pl.push_back(w[8*k +: 8]);
    endtask

    // Frame-level reference: decide the event purely from class, id, length and checksum.
    task automatic predict(input logic [7:0] cls, input logic [7:0] id, input bit bad);
        int len;
        len = pl.size();
        if (bad) begin
            push_kind(3);
        end else if (cls == 8'h01 && id == 8'h02 && len == 28) begin
            model.lon = pl_get(1); model.lat = pl_get(2); model.hmsl = pl_get(4);
            push_kind(0);
        end else if (cls == 8'h01 && id == 8'h12 && len == 36) begin
            model.vn = pl_get(1); model.ve = pl_get(2); model.vd = pl_get(3);
            model.gs = pl_get(5); model.hd = pl_get(6);
            push_kind(1);
        end else if (cls == 8'h05 && (id == 8'h01 || id == 8'h00) && len == 2) begin
            model.ok = (id == 8'h01); model.ac = pl[0]; model.ai = pl[1];
            push_kind(2);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gaps;
        gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int g = 0; g < gaps; g++) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    // corrupt: 0 none, 1 flip CK_A bit 0, 2 flip CK_B bit 0
    task automatic send_frame(input logic [7:0] cls, input logic [7:0] id, input int corrupt);
        logic [7:0]  a, b;
        logic [15:0] len;
        logic [7:0]  body[$];
        len  = 16'(pl.size());
        body = {cls, id, len[7:0], len[15:8]};
        foreach (pl[i]) body.push_back(pl[i]);
        a = 0; b = 0;
        foreach (body[i]) begin a = a + body[i]; b = b + a; end
        send_byte(8'hB5);
        send_byte(8'h62);
        foreach (body[i]) send_byte(body[i]);
        send_byte(a ^ ((corrupt == 1) ? 8'h01 : 8'h00));
        predict(cls, id, corrupt != 0);
        send_byte(b ^ ((corrupt == 2) ? 8'h01 : 8'h00));
    endtask

    task automatic send_long_header(input logic [15:0] len);
        send_byte(8'hB5); send_byte(8'h62); send_byte(8'h01); send_byte(8'h02);
        send_byte(len[7:0]);
        push_kind(3);
        send_byte(len[15:8]);
    endtask

    task automatic gen_posllh(input logic [31:0] lo, input logic [31:0] la, input logic [31:0] hm);
        pl.delete();
        pl_word($urandom); pl_word(lo); pl_word(la); pl_word($urandom);
        pl_word(hm); pl_word($urandom); pl_word($urandom);
    endtask

    task automatic gen_velned(input logic [31:0] vn, input logic [31:0] ve, input logic [31:0] vd,
                              input logic [31:0] gs, input logic [31:0] hd);
        pl.delete();
        pl_word($urandom); pl_word(vn); pl_word(ve); pl_word(vd); pl_word($urandom);
        pl_word(gs); pl_word(hd); pl_word($urandom); pl_word($urandom);
    endtask

    task automatic gen_random(input int len);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lon"}, lon, 0);       chk({tag, "_lat"}, lat, 0);
        chk({tag, "_hmsl"}, hmsl, 0);     chk({tag, "_vel_n"}, vel_n, 0);
        chk({tag, "_vel_e"}, vel_e, 0);   chk({tag, "_vel_d"}, vel_d, 0);
        chk({tag, "_gspeed"}, gspeed, 0); chk({tag, "_heading"}, heading, 0);
        chk({tag, "_pulses"}, 32'({posllh_valid, velned_valid, ack_valid, frame_err}), 0);
        chk({tag, "_ack"}, 32'({ack_ok, ack_class, ack_id}), 0);
    endtask

    // Monitor: every output pulse must match the oldest predicted event.
    initial begin
        int   n, kind, txn;
        exp_t e;
        txn = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                n = int'(posllh_valid) + int'(velned_valid) + int'(ack_valid) + int'(frame_err);
                if (n != 0) begin
                    if (n > 1) chk("pulse_onehot", 32'(n), 32'd1);
                    kind = posllh_valid ? 0 : velned_valid ? 1 : ack_valid ? 2 : 3;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse actual_kind=%0d required=none", kind);
                    end else begin
                        e = exp_q.pop_front();
                        txn++;
                        chk("kind", 32'(kind), 32'(e.kind));
                        chk("lon", lon, e.lon);       chk("lat", lat, e.lat);
                        chk("hmsl", hmsl, e.hmsl);    chk("vel_n", vel_n, e.vn);
                        chk("vel_e", vel_e, e.ve);    chk("vel_d", vel_d, e.vd);
                        chk("gspeed", gspeed, e.gs);  chk("heading", heading, e.hd);
                        chk("ack_ok", 32'(ack_ok), 32'(e.ok));
                        chk("ack_class", 32'(ack_class), 32'(e.ac));
                        chk("ack_id", 32'(ack_id), 32'(e.ai));
                        $display("txn %0d kind %0d lon %h vel_d %h ack %0d/%h/%h",
                                 txn, kind, lon, vel_d, ack_ok, ack_class, ack_id);
                    end
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        int sel;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Literal ACK frame with its published checksum bytes.
        model.ok = 1'b1; model.ac = 8'h06; model.ai = 8'h24;
        send_byte(8'hB5); send_byte(8'h62); send_byte(8'h05); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h06); send_byte(8'h24);
        send_byte(8'h32);
        push_kind(2);
        send_byte(8'h5B);

        gen_posllh(32'h0A1B2C3D, 32'hFE000001, 32'd1234);
        send_frame(8'h01, 8'h02, 0);
        send_frame(8'h01, 8'h02, 2);

        send_byte(8'h00); send_byte(8'hB5);
        gen_velned(32'd120, -32'sd77, -32'sd50, 32'd141, 32'd9000000);
        send_frame(8'h01, 8'h12, 0);

        send_long_header(16'h0100);
        pl = {8'h06, 8'h01};
        send_frame(8'h05, 8'h00, 0);

        // Good frames that must be consumed with no pulse, incl. len 0 and len == MAX_LEN.
        gen_random(4);  send_frame(8'h06, 8'h24, 0);
        gen_random(20); send_frame(8'h01, 8'h02, 0);
        gen_random(0);  send_frame(8'h0A, 8'h04, 0);
        gen_random(64); send_frame(8'h01, 8'h12, 0);
        send_long_header(16'd65);
        gen_velned($urandom, $urandom, $urandom, $urandom, $urandom);
        send_frame(8'h01, 8'h12, 1);

        // Reset in the middle of a POSLLH payload.
        send_byte(8'hB5); send_byte(8'h62); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h1C); send_byte(8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        gen_posllh($urandom, $urandom, $urandom);
        send_frame(8'h01, 8'h02, 0);

        for (int f = 0; f < 150; f++) begin
            gap_max = ($urandom_range(0, 1) == 1) ? 3 : 0;
            for (int k = int'($urandom_range(0, 3)); k > 0; k--)
                send_byte(8'($urandom_range(0, 8'hB4)));
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: begin gen_posllh($urandom, $urandom, $urandom); send_frame(8'h01, 8'h02, 0); end
                1: begin
                    gen_velned($urandom, $urandom, $urandom, $urandom, $urandom);
                    send_frame(8'h01, 8'h12, 0);
                end
                2: begin gen_random(2); send_frame(8'h05, 8'h01, 0); end
                3: begin gen_random(2); send_frame(8'h05, 8'h00, 0); end
                4: begin gen_random(int'($urandom_range(0, 64))); send_frame(8'h06, 8'h01, 0); end
                5: begin gen_posllh($urandom, $urandom, $urandom); send_frame(8'h01, 8'h02, 1); end
                6: begin
                    gen_velned($urandom, $urandom, $urandom, $urandom, $urandom);
                    send_frame(8'h01, 8'h12, 2);
                end
                default: send_long_header(16'($urandom_range(65, 300)));
            endcase
        end

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 100) begin
            @(posedge clk);
            wait_cycles++;
        end
        repeat (2) @(posedge clk);
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
